// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared constants, state type and count-width helper for serial2parallel_hs
package s2p_pkg;

    // Bit-order selector values for the MSB_FIRST parameter.
    localparam int S2P_LSB_FIRST = 0;
    localparam int S2P_MSB_FIRST = 1;

    // Collector state: IDLE means no bits of the current frame received yet.
    typedef enum logic {
        S2P_IDLE    = 1'b0,
        S2P_COLLECT = 1'b1
    } s2p_state_e;

    // Width needed to hold a bit count in the range 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/s2p_out_buf.sv
// rtl/s2p_out_buf.sv - single-entry valid/ready holding register with overflow pulse
module s2p_out_buf
    import s2p_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overflow
);

    // Hold one word until the consumer takes it; a load arriving while the
    // entry is full and not draining is dropped and flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= load && valid && !ready;
            if (load && (!valid || ready)) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                // Emptying the entry also clears any status carried with the word.
                data  <= '0;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial2parallel_hs.sv
// rtl/serial2parallel_hs.sv - gap-tolerant serial-to-parallel deserialiser with valid/ready output; S2P_PARITY_EN adds an even-parity bit per frame
module serial2parallel_hs
    import s2p_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = S2P_MSB_FIRST
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      din_serial,
    input  logic                      din_valid,
    input  logic                      flush,
    input  logic                      dout_ready,
    output logic [WIDTH-1:0]          dout_parallel,
    output logic                      dout_valid,
    output logic                      overflow,
`ifdef S2P_PARITY_EN
    output logic                      parity_err,
`endif
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = cnt_w(WIDTH);

`ifdef S2P_PARITY_EN
    // Frame is WIDTH data bits plus a trailing even-parity bit.
    localparam int FRAME = WIDTH + 1;
    localparam int BW    = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
    localparam int BW    = WIDTH;
`endif

    // Count value held just before the completion edge.
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    s2p_state_e       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             complete;
    logic [BW-1:0]    load_data;
    logic [BW-1:0]    buf_data;

    // Next shift-register value with the incoming bit inserted at the entry end.
    always_comb begin
        shreg_nxt = shreg;
        if (MSB_FIRST != S2P_LSB_FIRST) begin
            shreg_nxt = {shreg[WIDTH-2:0], din_serial};
        end else begin
            shreg_nxt = {din_serial, shreg[WIDTH-1:1]};
        end
    end

    // A sampled bit that finishes the frame; flush overrides completion.
    assign complete = din_valid && !flush && (bit_cnt == LAST);

    // Word handed to the output stage on the completion edge.
    always_comb begin
        load_data = '0;
`ifdef S2P_PARITY_EN
        // Data bits are already all in the shift register; the last bit is parity.
        load_data = {(^shreg) ^ din_serial, shreg};
`else
        load_data = shreg_nxt;
`endif
    end

    // Collector FSM: count and shift on each qualified bit, hold across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S2P_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (flush) begin
            state   <= S2P_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (din_valid) begin
            if (bit_cnt == LAST) begin
                state   <= S2P_IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
            end else begin
                state   <= S2P_COLLECT;
                bit_cnt <= (state == S2P_IDLE) ? CW'(1) : bit_cnt + CW'(1);
                shreg   <= shreg_nxt;
            end
        end
    end

    s2p_out_buf #(
        .WIDTH (BW)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_data (load_data),
        .ready     (dout_ready),
        .data      (buf_data),
        .valid     (dout_valid),
        .overflow  (overflow)
    );

    assign dout_parallel = buf_data[WIDTH-1:0];
`ifdef S2P_PARITY_EN
    assign parity_err    = buf_data[WIDTH];
`endif

endmodule

// File: tb/tb_serial2parallel_hs.sv
// tb/tb_serial2parallel_hs.sv - directed self-checking bench for serial2parallel_hs, MSB-first and LSB-first instances
module tb_serial2parallel_hs;

`ifdef S2P_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_serial;
    logic       din_valid;
    logic       flush;
    logic       dout_ready;

    logic [7:0] m_dout, l_dout;
    logic       m_valid, l_valid;
    logic       m_ovf, l_ovf;
    logic [3:0] m_cnt, l_cnt;
`ifdef S2P_PARITY_EN
    logic       m_perr, l_perr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial2parallel_hs #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_serial    (din_serial),
        .din_valid     (din_valid),
        .flush         (flush),
        .dout_ready    (dout_ready),
        .dout_parallel (m_dout),
        .dout_valid    (m_valid),
        .overflow      (m_ovf),
`ifdef S2P_PARITY_EN
        .parity_err    (m_perr),
`endif
        .bit_cnt       (m_cnt)
    );

    serial2parallel_hs #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_serial    (din_serial),
        .din_valid     (din_valid),
        .flush         (flush),
        .dout_ready    (dout_ready),
        .dout_parallel (l_dout),
        .dout_valid    (l_valid),
        .overflow      (l_ovf),
`ifdef S2P_PARITY_EN
        .parity_err    (l_perr),
`endif
        .bit_cnt       (l_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fl);
        din_serial = b;
        din_valid  = 1'b1;
        flush      = fl;
        tick();
        din_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    // Bits go out w[7] first; fl applies flush on the frame's final bit.
    task automatic send_frame_p(input logic [7:0] w, input logic p, input logic fl);
        for (int i = 7; i >= 0; i--) send_bit(w[i], fl && (i == 0) && !PAR);
        if (PAR) send_bit(p, fl);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic fl);
        send_frame_p(w, ^w, fl);
    endtask

    initial begin
        rst_n      = 1'b0;
        din_serial = 1'b0;
        din_valid  = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b1;
        tick();
        tick();
        check("rst_dout",  {24'd0, m_dout}, 32'h0);
        check("rst_valid", {31'd0, m_valid}, 32'h0);
        check("rst_ovf",   {31'd0, m_ovf}, 32'h0);
        check("rst_cnt",   {28'd0, m_cnt}, 32'h0);
        check("rst_cnt_l", {28'd0, l_cnt}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1,0,1,0,0,1,0,1 -> A5 in both orders; valid for exactly one cycle
        send_frame(8'hA5, 1'b0);
        check("a5_valid",  {31'd0, m_valid}, 32'h1);
        check("a5_msb",    {24'd0, m_dout}, 32'hA5);
        check("a5_lsb",    {24'd0, l_dout}, 32'hA5);
        check("a5_cnt",    {28'd0, m_cnt}, 32'h0);
`ifdef S2P_PARITY_EN
        check("a5_perr",   {31'd0, m_perr}, 32'h0);
`endif
        tick();
        check("a5_1cyc",   {31'd0, m_valid}, 32'h0);

        // 1,0,0,0,0,0,0,0 -> 80 MSB-first, 01 LSB-first
        send_frame(8'h80, 1'b0);
        check("p80_msb",   {24'd0, m_dout}, 32'h80);
        check("p01_lsb",   {24'd0, l_dout}, 32'h01);
        tick();

        // gap of three cycles after bit 4
        for (int i = 7; i >= 4; i--) send_bit(8'hC3 >> i, 1'b0);
        tick();
        tick();
        tick();
        check("gap_cnt",   {28'd0, m_cnt}, 32'h4);
        check("gap_valid", {31'd0, m_valid}, 32'h0);
        for (int i = 3; i >= 0; i--) send_bit(8'hC3 >> i, 1'b0);
        if (PAR) send_bit(^8'hC3, 1'b0);
        check("gap_word",  {24'd0, m_dout}, 32'hC3);
        check("gap_wvld",  {31'd0, m_valid}, 32'h1);
        tick();

        // consumer stalled: second word overflows, first held
        dout_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        send_frame(8'hFF, 1'b0);
        check("ovf_pulse", {31'd0, m_ovf}, 32'h1);
        check("ovf_pls_l", {31'd0, l_ovf}, 32'h1);
        check("ovf_hold",  {24'd0, m_dout}, 32'h3C);
        check("ovf_cnt",   {28'd0, m_cnt}, 32'h0);
        tick();
        check("ovf_1cyc",  {31'd0, m_ovf}, 32'h0);
        check("ovf_hold2", {24'd0, m_dout}, 32'h3C);
        check("ovf_vld",   {31'd0, m_valid}, 32'h1);
        dout_ready = 1'b1;
        tick();
        check("ovf_xfer",  {31'd0, m_valid}, 32'h0);

        // flush after five bits, then a clean word
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("fl_cnt5",   {28'd0, m_cnt}, 32'h5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_cnt0",   {28'd0, m_cnt}, 32'h0);
        send_frame(8'h81, 1'b0);
        check("fl_word",   {24'd0, m_dout}, 32'h81);
        check("fl_word_l", {24'd0, l_dout}, 32'h81);
        tick();

        // flush on the completion edge discards the word
        send_frame(8'h3C, 1'b1);
        check("flc_valid", {31'd0, m_valid}, 32'h0);
        check("flc_cnt",   {28'd0, m_cnt}, 32'h0);
        tick();
        check("flc_vld2",  {31'd0, m_valid}, 32'h0);

        // reset mid-word
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        check("rw_cnt6",   {28'd0, m_cnt}, 32'h6);
        rst_n = 1'b0;
        #1;
        check("rw_cnt0",   {28'd0, m_cnt}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset while a word is held
        dout_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        check("rh_valid",  {31'd0, m_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rh_vld0",   {31'd0, m_valid}, 32'h0);
        check("rh_dout0",  {24'd0, m_dout}, 32'h0);
        tick();
        rst_n = 1'b1;
        dout_ready = 1'b1;
        tick();
        send_frame(8'h81, 1'b0);
        check("post_rst",  {24'd0, m_dout}, 32'h81);
        tick();

`ifdef S2P_PARITY_EN
        send_frame_p(8'h07, 1'b1, 1'b0);
        check("par_ok_m",  {24'd0, m_dout}, 32'h07);
        check("par_ok_l",  {24'd0, l_dout}, 32'hE0);
        check("par_ok_e",  {31'd0, m_perr}, 32'h0);
        tick();
        send_frame_p(8'h07, 1'b0, 1'b0);
        check("par_bad_v", {31'd0, m_valid}, 32'h1);
        check("par_bad_d", {24'd0, m_dout}, 32'h07);
        check("par_bad_e", {31'd0, m_perr}, 32'h1);
        check("par_bad_l", {31'd0, l_perr}, 32'h1);
        tick();
        check("par_clr",   {31'd0, m_perr}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
